// File: rtl/preg_free_list_ctrl.sv
// Physical-register free list for rename: circular free-preg buffer with a post-reset
// init walk, two in-order alloc lanes, two commit free lanes and one branch checkpoint.
module preg_free_list_ctrl #(
  parameter int NUM_PREGS = 128,
  parameter int ARCH_REGS = 32,
  parameter int PW        = $clog2(NUM_PREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_req0,
  input  logic          alloc_req1,
  output logic          alloc_gnt0,
  output logic          alloc_gnt1,
  output logic [PW-1:0] alloc_preg0,
  output logic [PW-1:0] alloc_preg1,
  input  logic          free_v0,
  input  logic          free_v1,
  input  logic [PW-1:0] free_preg0,
  input  logic [PW-1:0] free_preg1,
  input  logic          ckpt_save,
  input  logic          ckpt_restore,
  output logic [PW:0]   free_count,
  output logic          ready,
  output logic          overflow_err
);

  localparam logic [0:0]    S_INIT    = 1'b0;
  localparam logic [0:0]    S_READY   = 1'b1;
  localparam logic [PW-1:0] INIT_LAST = PW'(NUM_PREGS - ARCH_REGS - 1);
  localparam logic [PW:0]   DEPTH     = (PW+1)'(NUM_PREGS);

  logic [PW-1:0] fl_buf [NUM_PREGS];
  logic [0:0]    state;
  logic [PW-1:0] init_cnt;
  logic [PW:0]   w_ptr, r_ptr, ckpt_ptr, count;
  logic [PW:0]   r_alloc, r_nxt, w_nxt;
  logic [PW-1:0] r_idx1, w_idx1;
  logic          ckpt_valid, in_ready, acc0, acc1;

  assign in_ready = (state == S_READY);
  assign count    = w_ptr - r_ptr;

  assign alloc_gnt0  = in_ready & alloc_req0 & (count != '0) & ~ckpt_restore;
  assign alloc_gnt1  = alloc_req1 & alloc_gnt0 & (count >= (PW+1)'(2));
  assign r_idx1      = r_ptr[PW-1:0] + PW'(1);
  assign alloc_preg0 = fl_buf[r_ptr[PW-1:0]];
  assign alloc_preg1 = fl_buf[r_idx1];
  assign r_alloc     = r_ptr + (PW+1)'(alloc_gnt0) + (PW+1)'(alloc_gnt1);

  // Fullness for lane 1 counts lane 0's accepted free; allocations this cycle do not make room.
  assign acc0   = in_ready & free_v0 & (count < DEPTH);
  assign acc1   = in_ready & free_v1 & ((count + (PW+1)'(acc0)) < DEPTH);
  assign w_idx1 = w_ptr[PW-1:0] + PW'(acc0);

  always_comb begin
    w_nxt = w_ptr;
    r_nxt = r_ptr;
    if (!in_ready) begin
      w_nxt = w_ptr + (PW+1)'(1);
    end else begin
      w_nxt = w_ptr + (PW+1)'(acc0) + (PW+1)'(acc1);
      r_nxt = (ckpt_restore && ckpt_valid) ? ckpt_ptr : r_alloc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_INIT;
      init_cnt     <= '0;
      w_ptr        <= '0;
      r_ptr        <= '0;
      ckpt_valid   <= 1'b0;
      ckpt_ptr     <= '0;
      ready        <= 1'b0;
      free_count   <= '0;
      overflow_err <= 1'b0;
    end else begin
      w_ptr      <= w_nxt;
      r_ptr      <= r_nxt;
      free_count <= w_nxt - r_nxt;
      if (!in_ready) begin
        init_cnt <= init_cnt + PW'(1);
        if (init_cnt == INIT_LAST) begin
          state <= S_READY;
          ready <= 1'b1;
        end
      end else begin
        // Restore has priority: a save in the same cycle is discarded.
        if (ckpt_restore) begin
          ckpt_valid <= 1'b0;
        end else if (ckpt_save) begin
          ckpt_valid <= 1'b1;
          ckpt_ptr   <= r_alloc;
        end
        if ((free_v0 && !acc0) || (free_v1 && !acc1)) overflow_err <= 1'b1;
      end
    end
  end

  // Storage is not reset; the init walk rewrites every slot that can be allocated.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!in_ready) begin
        fl_buf[init_cnt] <= PW'(ARCH_REGS) + init_cnt;
      end else begin
        if (acc0) fl_buf[w_ptr[PW-1:0]] <= free_preg0;
        if (acc1) fl_buf[w_idx1]        <= free_preg1;
      end
    end
  end

endmodule

// File: tb/tb_preg_free_list_ctrl.sv
// Vector/scoreboard bench for preg_free_list_ctrl: stimulus pushes expected outputs,
// a negedge checker pops and compares them against the DUT.
module tb_preg_free_list_ctrl;
  localparam int PW = 7;

  logic clk = 1'b0;
  logic rst_n, alloc_req0, alloc_req1, free_v0, free_v1, ckpt_save, ckpt_restore;
  logic [PW-1:0] free_preg0, free_preg1;
  logic alloc_gnt0, alloc_gnt1, ready, overflow_err;
  logic [PW-1:0] alloc_preg0, alloc_preg1;
  logic [PW:0] free_count;

  preg_free_list_ctrl #(.NUM_PREGS(128), .ARCH_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req0(alloc_req0), .alloc_req1(alloc_req1),
    .alloc_gnt0(alloc_gnt0), .alloc_gnt1(alloc_gnt1),
    .alloc_preg0(alloc_preg0), .alloc_preg1(alloc_preg1),
    .free_v0(free_v0), .free_v1(free_v1),
    .free_preg0(free_preg0), .free_preg1(free_preg1),
    .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .free_count(free_count), .ready(ready), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, r0, r1, f0, f1, sv, rs;
    int   fp0, fp1;
    logic g0, g1;
    int   cp;          // 0: ignore pregs, 1: check preg0, 2: check both
    int   p0, p1, cnt;
    logic rdy, ovf;
  } vec_t;

  vec_t exp_q[$];
  int nvec = 0;
  int nmis = 0;

  function automatic vec_t mk(input logic r0, r1, f0, f1, input int fp0, fp1,
                              input logic sv, rs, g0, g1, input int cp, p0, p1, cnt,
                              input logic rdy, ovf);
    vec_t v;
    v.rst_n = 1'b1; v.r0 = r0; v.r1 = r1; v.f0 = f0; v.f1 = f1; v.fp0 = fp0; v.fp1 = fp1;
    v.sv = sv; v.rs = rs; v.g0 = g0; v.g1 = g1; v.cp = cp; v.p0 = p0; v.p1 = p1;
    v.cnt = cnt; v.rdy = rdy; v.ovf = ovf;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    rst_n = v.rst_n; alloc_req0 = v.r0; alloc_req1 = v.r1;
    free_v0 = v.f0; free_v1 = v.f1;
    free_preg0 = PW'(v.fp0); free_preg1 = PW'(v.fp1);
    ckpt_save = v.sv; ckpt_restore = v.rs;
    exp_q.push_back(v);
  endtask

  function automatic void chk(input int idx, input string n, input logic [31:0] a,
                              input logic [31:0] x);
    if (a !== x) begin
      nmis++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, n, a, x);
    end
  endfunction

  vec_t e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      nvec++;
      chk(nvec, "gnt0", 32'(alloc_gnt0), 32'(e.g0));
      chk(nvec, "gnt1", 32'(alloc_gnt1), 32'(e.g1));
      if (e.cp >= 1) chk(nvec, "preg0", 32'(alloc_preg0), e.p0);
      if (e.cp >= 2) chk(nvec, "preg1", 32'(alloc_preg1), e.p1);
      chk(nvec, "free_count", 32'(free_count), e.cnt);
      chk(nvec, "ready", 32'(ready), 32'(e.rdy));
      chk(nvec, "overflow_err", 32'(overflow_err), 32'(e.ovf));
    end
  end

  vec_t tD[3];
  vec_t tF[13];
  vec_t tG[5];

  initial begin
    // Post-drain empty corner, then free/alloc at count 0.
    tD[0] = mk(1,1,0,0, 0,0,  0,0, 0,0, 0,0,0, 0,1,0);
    tD[1] = mk(1,0,1,0, 40,0, 0,0, 0,0, 0,0,0, 0,1,0);
    tD[2] = mk(1,1,0,0, 0,0,  0,0, 1,0, 1,40,0, 1,1,0);
    // Checkpoint sequence from count 90 (buffer holds 0..89 in order).
    tF[0]  = mk(1,1,0,0, 0,0,  1,0, 1,1, 2,0,1, 90,1,0);
    tF[1]  = mk(1,1,0,0, 0,0,  0,0, 1,1, 2,2,3, 88,1,0);
    tF[2]  = mk(1,1,0,0, 0,0,  0,0, 1,1, 2,4,5, 86,1,0);
    tF[3]  = mk(1,1,0,0, 0,0,  0,0, 1,1, 2,6,7, 84,1,0);
    tF[4]  = mk(1,1,0,0, 0,0,  0,1, 0,0, 0,0,0, 82,1,0);
    tF[5]  = mk(0,0,0,0, 0,0,  0,0, 0,0, 2,2,3, 88,1,0);
    tF[6]  = mk(1,0,1,0, 77,0, 0,1, 0,0, 0,0,0, 88,1,0);
    tF[7]  = mk(0,0,0,0, 0,0,  0,0, 0,0, 1,2,0, 89,1,0);
    tF[8]  = mk(0,0,0,0, 0,0,  1,0, 0,0, 0,0,0, 89,1,0);
    tF[9]  = mk(1,1,0,0, 0,0,  0,0, 1,1, 2,2,3, 89,1,0);
    tF[10] = mk(1,0,0,0, 0,0,  1,1, 0,0, 0,0,0, 87,1,0);
    tF[11] = mk(0,0,0,0, 0,0,  0,1, 0,0, 0,0,0, 89,1,0);
    tF[12] = mk(0,0,0,0, 0,0,  0,0, 0,0, 2,2,3, 89,1,0);
    // Fullness: lane-1-only drop at 127, both dropped at 128, then mid-traffic reset.
    tG[0] = mk(0,0,1,1, 11,12, 0,0, 0,0, 0,0,0, 127,1,0);
    tG[1] = mk(0,0,1,1, 13,14, 0,0, 0,0, 0,0,0, 128,1,1);
    tG[2] = mk(0,0,1,0, 15,0,  0,0, 0,0, 0,0,0, 128,1,1);
    tG[3] = mk(1,0,0,0, 0,0,   0,0, 1,0, 2,2,3, 128,1,1);
    tG[4] = mk(0,0,1,0, 20,0,  0,0, 0,0, 0,0,0, 127,1,1);
    tG[4].rst_n = 1'b0;

    rst_n = 1'b0; alloc_req0 = 0; alloc_req1 = 0; free_v0 = 0; free_v1 = 0;
    free_preg0 = '0; free_preg1 = '0; ckpt_save = 0; ckpt_restore = 0;
    repeat (2) @(posedge clk);

    // Init walk: requests, frees and checkpoint ops are all ignored.
    for (int i = 0; i < 96; i++) apply(mk(1,1,1,0, 5,0, 1,0, 0,0, 0,0,0, i,0,0));
    for (int i = 0; i < 48; i++)
      apply(mk(1,1,0,0, 0,0, 0,0, 1,1, 2,32+2*i,33+2*i, 96-2*i,1,0));
    for (int i = 0; i < 3; i++) apply(tD[i]);
    for (int k = 0; k < 25; k++) apply(mk(0,0,1,1, 2*k,2*k+1, 0,0, 0,0, 0,0,0, 2*k,1,0));
    apply(mk(0,1,0,0, 0,0, 0,0, 0,0, 2,0,1, 50,1,0));
    for (int k = 25; k < 45; k++) apply(mk(0,0,1,1, 2*k,2*k+1, 0,0, 0,0, 0,0,0, 2*k,1,0));
    for (int i = 0; i < 13; i++) apply(tF[i]);
    for (int k = 0; k < 19; k++) apply(mk(0,0,1,1, 100+k,100+k, 0,0, 0,0, 0,0,0, 89+2*k,1,0));
    for (int i = 0; i < 5; i++) apply(tG[i]);
    for (int i = 0; i < 96; i++) apply(mk(1,1,1,0, 5,0, 0,1, 0,0, 0,0,0, i,0,0));
    apply(mk(0,0,0,0, 0,0, 0,0, 0,0, 2,32,33, 96,1,0));

    @(posedge clk);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
